alu_writeback: RTL and testbench
================================

Name: alu_writeback

Overview:
- Sits directly downstream of the ALU in the 6502 datapath.
- Captures the ALU Result and PSRout and writes the result into A, X or Y.
- Merges the ALU flags into the architectural processor status register P, under a per-instruction mask.
- Also handles the flag instructions (SEC/CLC/SEI/CLI/SED/CLD/CLV), PLP, interrupt entry and PHP push data. Feeds CarryBit and Decimal back to the ALU.

Parameters:
- P_RESET, 8'h34, value loaded into P on reset (I=1, bit5=1, B=1).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- wb_valid  in  1  ALU result valid this cycle.
- wb_result  in  8  ALU Result.
- wb_psr  in  8  ALU PSRout, layout N V 1 B D I Z C (bit7..bit0).
- wb_dest  in  2  00 none, 01 A, 10 X, 11 Y.
- wb_flag_mask  in  8  1 = take that P bit from the writeback.
- wb_nz_auto  in  1  1 = derive N/Z from wb_result instead of wb_psr (loads, transfers).
- flag_op_valid  in  1  flag instruction strobe.
- flag_op  in  3  0 CLC, 1 SEC, 2 CLI, 3 SEI, 4 CLD, 5 SED, 6 CLV, 7 no-op.
- plp_valid  in  1  load P from the stack.
- plp_data  in  8  byte pulled from the stack.
- irq_entry  in  1  interrupt/BRK entry strobe; sets I.
- reg_a  out  8  accumulator.
- reg_x  out  8  X index register.
- reg_y  out  8  Y index register.
- reg_p  out  8  status register.
- carry_out  out  1  reg_p[0], drives ALU CarryBit.
- decimal_out  out  1  reg_p[3], drives ALU Decimal.
- php_data  out  8  reg_p with bit5=1, bit4=1 (PHP/BRK push).
- irq_push_data  out  8  reg_p with bit5=1, bit4=0 (hardware IRQ/NMI push).
- wb_count  out  16  count of accepted wb_valid cycles, wraps at 16'hFFFF -> 0.

Behaviour:
- Reset: rst high at a clock edge gives reg_a/reg_x/reg_y = 0, reg_p = P_RESET, wb_count = 0. Reset overrides every other input in that cycle; an operation in flight is discarded.
- Latency: all writes are visible one cycle after the strobe edge. There is no combinational bypass; carry_out and decimal_out are registered values.
- Register write: if wb_valid and wb_dest != 00, the selected register <= wb_result. This happens independently of P priority (below). wb_dest = 00 writes no register.
- wb_count increments on every wb_valid cycle, including dest 00.
- P writer priority per cycle: plp_valid > irq_entry > flag_op_valid > wb_valid. Only the highest-priority active writer modifies P; lower ones are dropped for P only.
- plp: P <= plp_data with bit5 forced to 1 and bit4 forced to 1.
- irq_entry: P[2] <= 1; all other bits are held.
- flag_op: modifies only its target bit (C = bit0, I = bit2, D = bit3, V = bit6); flag_op 7 leaves P unchanged.
- wb: for each bit i with wb_flag_mask[i] = 1, P[i] <= src[i]; masked-off bits are held.
  - src = wb_psr, except when wb_nz_auto = 1: src[7] = wb_result[7] and src[1] = (wb_result == 0).
  - Mask bits 5 and 4 are ignored; P[5] and P[4] always read 1.
- Invariant: reg_p[5] = 1 and reg_p[4] = 1 at all times after reset.

Test Plan:
- Reset, then ADC result: rst for 2 cycles -> reg_p = 8'h34 and A/X/Y = 0. Then wb_valid, wb_result = 8'h80, wb_psr = 8'hF0, mask = 8'hC3, dest = A -> next cycle reg_a = 8'h80, reg_p = 8'hF4, carry_out = 0.
- Auto N/Z load: P = 8'h34; wb_result = 8'h00, dest = X, nz_auto = 1, mask = 8'h82, wb_psr = 8'hFF -> reg_x = 8'h00, reg_p = 8'h36 (Z=1, N=0).
- Flag ops: SEC, SED, CLI on successive cycles from P = 8'h34 -> reg_p = 8'h35, then 8'h3D, then 8'h39. decimal_out = 1 after SED.
- Priority collision: in one cycle plp_valid with plp_data = 8'h00, flag_op = SEC, and wb_valid with dest = Y, result = 8'h5A, mask = 8'hFF -> reg_p = 8'h30, reg_y = 8'h5A, wb_count += 1.
- Push data and IRQ: P = 8'h30; irq_entry -> reg_p = 8'h34. php_data = 8'h34 and irq_push_data = 8'h24 in the following cycle.
- Counter wrap and mid-op reset: preload 65535 wb cycles -> wb_count = 16'hFFFF, and the next wb_valid gives 0. Assert rst together with wb_valid and dest = A -> reg_a = 0, wb_count = 0.

Source files
------------

// File: rtl/alu_writeback_if.sv
// Writeback-stage bus between the ALU/control side and the architectural register file.
// The master drives the writeback, flag, PLP and interrupt strobes. The slave returns the register state.
interface alu_writeback_if;
    logic        wb_valid;
    logic [7:0]  wb_result;
    logic [7:0]  wb_psr;
    logic [1:0]  wb_dest;
    logic [7:0]  wb_flag_mask;
    logic        wb_nz_auto;
    logic        flag_op_valid;
    logic [2:0]  flag_op;
    logic        plp_valid;
    logic [7:0]  plp_data;
    logic        irq_entry;
    logic [7:0]  reg_a;
    logic [7:0]  reg_x;
    logic [7:0]  reg_y;
    logic [7:0]  reg_p;
    logic        carry_out;
    logic        decimal_out;
    logic [7:0]  php_data;
    logic [7:0]  irq_push_data;
    logic [15:0] wb_count;

    modport master (
        output wb_valid, wb_result, wb_psr, wb_dest, wb_flag_mask, wb_nz_auto,
        output flag_op_valid, flag_op, plp_valid, plp_data, irq_entry,
        input  reg_a, reg_x, reg_y, reg_p, carry_out, decimal_out,
        input  php_data, irq_push_data, wb_count
    );

    modport slave (
        input  wb_valid, wb_result, wb_psr, wb_dest, wb_flag_mask, wb_nz_auto,
        input  flag_op_valid, flag_op, plp_valid, plp_data, irq_entry,
        output reg_a, reg_x, reg_y, reg_p, carry_out, decimal_out,
        output php_data, irq_push_data, wb_count
    );
endinterface

// File: rtl/alu_writeback.sv
// 6502 writeback stage: commits the ALU result to A/X/Y and merges the flags into P.
// P has a single writer per cycle, chosen in the order PLP > IRQ entry > flag op > ALU writeback.
module alu_writeback #(
    parameter logic [7:0] P_RESET = 8'h34
) (
    input  logic           clk,
    input  logic           rst,
    alu_writeback_if.slave bus
);
    typedef enum logic [1:0] {
        DEST_NONE = 2'b00,
        DEST_A    = 2'b01,
        DEST_X    = 2'b10,
        DEST_Y    = 2'b11
    } dest_e;

    typedef enum logic [2:0] {
        OP_CLC = 3'd0,
        OP_SEC = 3'd1,
        OP_CLI = 3'd2,
        OP_SEI = 3'd3,
        OP_CLD = 3'd4,
        OP_SED = 3'd5,
        OP_CLV = 3'd6,
        OP_NOP = 3'd7
    } flag_op_e;

    logic [7:0]  r_a;
    logic [7:0]  r_x;
    logic [7:0]  r_y;
    logic [7:0]  r_p;
    logic [15:0] r_count;

    logic [7:0]  w_src;
    logic [7:0]  w_mask;
    logic [7:0]  w_p_next;

    // Loads and transfers take N/Z from the result byte, not from the ALU flag output.
    always_comb begin
        w_src = bus.wb_psr;
        if (bus.wb_nz_auto) begin
            w_src[7] = bus.wb_result[7];
            w_src[1] = (bus.wb_result == 8'h00);
        end
        w_mask = bus.wb_flag_mask & 8'hCF;
    end

    always_comb begin
        w_p_next = r_p;
        if (bus.plp_valid) begin
            w_p_next = bus.plp_data;
        end else if (bus.irq_entry) begin
            w_p_next[2] = 1'b1;
        end else if (bus.flag_op_valid) begin
            case (flag_op_e'(bus.flag_op))
                OP_CLC:  w_p_next[0] = 1'b0;
                OP_SEC:  w_p_next[0] = 1'b1;
                OP_CLI:  w_p_next[2] = 1'b0;
                OP_SEI:  w_p_next[2] = 1'b1;
                OP_CLD:  w_p_next[3] = 1'b0;
                OP_SED:  w_p_next[3] = 1'b1;
                OP_CLV:  w_p_next[6] = 1'b0;
                default: w_p_next = r_p;
            endcase
        end else if (bus.wb_valid) begin
            w_p_next = (r_p & ~w_mask) | (w_src & w_mask);
        end
        w_p_next[5] = 1'b1;
        w_p_next[4] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_p     <= P_RESET;
            r_count <= '0;
        end else begin
            r_p <= w_p_next;
            if (bus.wb_valid) begin
                r_count <= r_count + 16'd1;
                case (dest_e'(bus.wb_dest))
                    DEST_A:  r_a <= bus.wb_result;
                    DEST_X:  r_x <= bus.wb_result;
                    DEST_Y:  r_y <= bus.wb_result;
                    default: ;
                endcase
            end
        end
    end

    assign bus.reg_a         = r_a;
    assign bus.reg_x         = r_x;
    assign bus.reg_y         = r_y;
    assign bus.reg_p         = r_p;
    assign bus.carry_out     = r_p[0];
    assign bus.decimal_out   = r_p[3];
    assign bus.php_data      = r_p | 8'h30;
    assign bus.irq_push_data = (r_p | 8'h20) & 8'hEF;
    assign bus.wb_count      = r_count;
endmodule

// File: tb/tb_alu_writeback.sv
// Directed bench for alu_writeback: the stimulus side queues hand-computed register states.
// A negedge monitor compares the register state one cycle after each strobe.
module tb_alu_writeback;
    logic clk;
    logic rst;
    alu_writeback_if bus ();

    alu_writeback #(.P_RESET(8'h34)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [7:0]  a;
        logic [7:0]  x;
        logic [7:0]  y;
        logic [7:0]  p;
        logic [15:0] cnt;
        int unsigned due;
    } exp_t;

    exp_t        sb[$];
    int unsigned cycle  = 0;
    int unsigned total  = 0;
    int unsigned passed = 0;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic chk(input string name, input string field, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s.%s: got %h, expected %h", name, field, act, exp);
    endtask

    // Monitor: the register file presents its committed state on the negedge after the strobe edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].due <= cycle) begin
                e = sb.pop_front();
                chk(e.name, "reg_a", {8'h00, bus.reg_a}, {8'h00, e.a});
                chk(e.name, "reg_x", {8'h00, bus.reg_x}, {8'h00, e.x});
                chk(e.name, "reg_y", {8'h00, bus.reg_y}, {8'h00, e.y});
                chk(e.name, "reg_p", {8'h00, bus.reg_p}, {8'h00, e.p});
                chk(e.name, "wb_count", bus.wb_count, e.cnt);
                chk(e.name, "carry_out", {15'h0, bus.carry_out}, {15'h0, e.p[0]});
                chk(e.name, "decimal_out", {15'h0, bus.decimal_out}, {15'h0, e.p[3]});
                chk(e.name, "php_data", {8'h00, bus.php_data}, {8'h00, e.p | 8'h30});
                chk(e.name, "irq_push_data", {8'h00, bus.irq_push_data}, {8'h00, (e.p | 8'h20) & 8'hEF});
            end
        end
    end

    task automatic clear_inputs();
        rst               = 1'b0;
        bus.wb_valid      = 1'b0;
        bus.wb_result     = 8'h00;
        bus.wb_psr        = 8'h00;
        bus.wb_dest       = 2'b00;
        bus.wb_flag_mask  = 8'h00;
        bus.wb_nz_auto    = 1'b0;
        bus.flag_op_valid = 1'b0;
        bus.flag_op       = 3'd7;
        bus.plp_valid     = 1'b0;
        bus.plp_data      = 8'h00;
        bus.irq_entry     = 1'b0;
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    task automatic go(input string name, input logic [7:0] a, input logic [7:0] x,
                      input logic [7:0] y, input logic [7:0] p, input logic [15:0] cnt);
        exp_t e;
        e.name = name; e.a = a; e.x = x; e.y = y; e.p = p; e.cnt = cnt;
        e.due  = cycle + 1;
        sb.push_back(e);
        adv();
    endtask

    task automatic wb(input logic [7:0] res, input logic [7:0] psr, input logic [1:0] dest,
                      input logic [7:0] mask, input logic nz);
        bus.wb_valid = 1'b1; bus.wb_result = res; bus.wb_psr = psr;
        bus.wb_dest = dest; bus.wb_flag_mask = mask; bus.wb_nz_auto = nz;
    endtask

    task automatic fop(input logic [2:0] op);
        bus.flag_op_valid = 1'b1; bus.flag_op = op;
    endtask

    initial begin
        clear_inputs();
        #1;
        rst = 1'b1; adv();
        rst = 1'b1; go("reset", 8'h00, 8'h00, 8'h00, 8'h34, 16'd0);

        wb(8'h80, 8'hF0, 2'b01, 8'hC3, 1'b0); go("adc", 8'h80, 8'h00, 8'h00, 8'hF4, 16'd1);

        rst = 1'b1; go("reset2", 8'h00, 8'h00, 8'h00, 8'h34, 16'd0);
        wb(8'h11, 8'h00, 2'b10, 8'h00, 1'b0); go("ldx_setup", 8'h00, 8'h11, 8'h00, 8'h34, 16'd1);
        wb(8'h00, 8'hFF, 2'b10, 8'h82, 1'b1); go("nz_auto", 8'h00, 8'h00, 8'h00, 8'h36, 16'd2);

        bus.plp_valid = 1'b1; bus.plp_data = 8'h34; go("plp_34", 8'h00, 8'h00, 8'h00, 8'h34, 16'd2);
        fop(3'd1); go("sec", 8'h00, 8'h00, 8'h00, 8'h35, 16'd2);
        fop(3'd5); go("sed", 8'h00, 8'h00, 8'h00, 8'h3D, 16'd2);
        fop(3'd2); go("cli", 8'h00, 8'h00, 8'h00, 8'h39, 16'd2);

        bus.plp_valid = 1'b1; bus.plp_data = 8'h00; fop(3'd1);
        wb(8'h5A, 8'hFF, 2'b11, 8'hFF, 1'b0);
        go("collision", 8'h00, 8'h00, 8'h5A, 8'h30, 16'd3);

        bus.irq_entry = 1'b1; go("irq", 8'h00, 8'h00, 8'h5A, 8'h34, 16'd3);
        bus.irq_entry = 1'b1; fop(3'd2); go("irq_over_cli", 8'h00, 8'h00, 8'h5A, 8'h34, 16'd3);
        wb(8'hAA, 8'h00, 2'b00, 8'h30, 1'b0); go("mask54_dest0", 8'h00, 8'h00, 8'h5A, 8'h34, 16'd4);

        bus.plp_valid = 1'b1; bus.plp_data = 8'hFF; go("plp_ff", 8'h00, 8'h00, 8'h5A, 8'hFF, 16'd4);
        fop(3'd6); go("clv", 8'h00, 8'h00, 8'h5A, 8'hBF, 16'd4);
        fop(3'd0); go("clc", 8'h00, 8'h00, 8'h5A, 8'hBE, 16'd4);
        fop(3'd4); go("cld", 8'h00, 8'h00, 8'h5A, 8'hB6, 16'd4);
        fop(3'd3); go("sei", 8'h00, 8'h00, 8'h5A, 8'hB6, 16'd4);
        fop(3'd7); go("flag_nop", 8'h00, 8'h00, 8'h5A, 8'hB6, 16'd4);
        wb(8'h80, 8'h00, 2'b01, 8'h82, 1'b1); go("nz_auto_neg", 8'h80, 8'h00, 8'h5A, 8'hB4, 16'd5);

        rst = 1'b1; go("reset3", 8'h00, 8'h00, 8'h00, 8'h34, 16'd0);
        for (int i = 0; i < 65534; i++) begin
            wb(8'h00, 8'h00, 2'b00, 8'h00, 1'b0); adv();
        end
        wb(8'h00, 8'h00, 2'b00, 8'h00, 1'b0); go("cnt_ffff", 8'h00, 8'h00, 8'h00, 8'h34, 16'hFFFF);
        wb(8'h00, 8'h00, 2'b00, 8'h00, 1'b0); go("cnt_wrap", 8'h00, 8'h00, 8'h00, 8'h34, 16'h0000);
        wb(8'h77, 8'h00, 2'b01, 8'h00, 1'b0); go("post_wrap", 8'h77, 8'h00, 8'h00, 8'h34, 16'd1);
        rst = 1'b1; wb(8'h99, 8'hFF, 2'b01, 8'hFF, 1'b0);
        go("rst_mid_op", 8'h00, 8'h00, 8'h00, 8'h34, 16'd0);

        for (int i = 0; i < 5 && sb.size() > 0; i++) @(posedge clk);
        @(negedge clk);
        #1;
        if (sb.size() > 0) begin
            total++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
